frame_reduce: RTL and testbench

Streaming, parametrised successor to the 4-bit combinational AND/OR/XOR reduction gate. It accepts a frame of WIDTH-bit words over a valid/ready handshake and reduces every bit of every word in the frame to one AND, one OR and one XOR bit. It reports the word count and a sticky overflow flag. Results are held in a single-entry output register with backpressure. It sits between a word source (e.g. a packet/CRC datapath) and any consumer needing frame-level parity or all-ones/all-zeros detection.

---
 rtl/frame_reduce_pkg.sv | 15 +
 rtl/frame_reduce_word_reduce.sv | 16 +
 rtl/frame_reduce.sv | 142 ++++++++++++++
 tb/tb_frame_reduce.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_reduce_pkg.sv
// Shared types and accumulator identities for frame_reduce.
// Used by the top level; word_reduce has no state and needs none of it.
package frame_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic AND_ID = 1'b1;
  localparam logic OR_ID  = 1'b0;
  localparam logic XOR_ID = 1'b0;

endpackage

// File: rtl/frame_reduce_word_reduce.sv
// Combinational reduction of one WIDTH-bit word to AND, OR and XOR bits.
// Zero latency, no flow control.
module word_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
);

  assign red_and = &word;
  assign red_or  = |word;
  assign red_xor = ^word;

endmodule

// File: rtl/frame_reduce.sv
// Reduces a frame of words to AND/OR/XOR bits plus a saturating word count and overflow flag.
// Result valid one cycle after the in_last word; single-entry output register, in_ready low while it is unconsumed.
module frame_reduce
  import frame_reduce_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 16,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  state_t        state_q, state_d;
  logic          acc_and_q, acc_and_d;
  logic          acc_or_q, acc_or_d;
  logic          acc_xor_q, acc_xor_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic          acc_ovf_q, acc_ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          out_and_q, out_and_d;
  logic          out_or_q, out_or_d;
  logic          out_xor_q, out_xor_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_ovf_q, out_ovf_d;

  logic          w_and, w_or, w_xor;
  logic          accept, at_max;
  logic          fold_and, fold_or, fold_xor, fold_ovf;
  logic [CW-1:0] fold_cnt;

  word_reduce #(.WIDTH(WIDTH)) u_word_reduce (
    .word    (in_data),
    .red_and (w_and),
    .red_or  (w_or),
    .red_xor (w_xor)
  );

  assign in_ready = rst_n && ((state_q != HOLD) || out_ready);
  assign accept   = in_valid && in_ready;

  // Accumulators sit at identity outside ACC, so the same fold serves the first word of a frame.
  assign at_max   = (acc_cnt_q == CW'(MAX_WORDS));
  assign fold_and = acc_and_q & w_and;
  assign fold_or  = acc_or_q | w_or;
  assign fold_xor = acc_xor_q ^ w_xor;
  assign fold_cnt = at_max ? acc_cnt_q : acc_cnt_q + CW'(1);
  assign fold_ovf = acc_ovf_q | at_max;

  always_comb begin
    state_d     = state_q;
    acc_and_d   = acc_and_q;
    acc_or_d    = acc_or_q;
    acc_xor_d   = acc_xor_q;
    acc_cnt_d   = acc_cnt_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid_q;
    out_and_d   = out_and_q;
    out_or_d    = out_or_q;
    out_xor_d   = out_xor_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end

    if (accept) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_and_d   = fold_and;
        out_or_d    = fold_or;
        out_xor_d   = fold_xor;
        out_count_d = fold_cnt;
        out_ovf_d   = fold_ovf;
        acc_and_d   = AND_ID;
        acc_or_d    = OR_ID;
        acc_xor_d   = XOR_ID;
        acc_cnt_d   = '0;
        acc_ovf_d   = 1'b0;
        state_d     = HOLD;
      end else begin
        acc_and_d = fold_and;
        acc_or_d  = fold_or;
        acc_xor_d = fold_xor;
        acc_cnt_d = fold_cnt;
        acc_ovf_d = fold_ovf;
        state_d   = ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_and_q   <= AND_ID;
      acc_or_q    <= OR_ID;
      acc_xor_q   <= XOR_ID;
      acc_cnt_q   <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_and_q   <= 1'b0;
      out_or_q    <= 1'b0;
      out_xor_q   <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_and_q   <= acc_and_d;
      acc_or_q    <= acc_or_d;
      acc_xor_q   <= acc_xor_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_xor_q   <= out_xor_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_and      = out_and_q;
  assign out_or       = out_or_q;
  assign out_xor      = out_xor_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_frame_reduce.sv
// Directed and randomized checks of frame_reduce against a frame-level reference model.
module tb_frame_reduce;

  localparam int W  = 4;
  localparam int MW = 16;
  localparam int CW = $clog2(MW + 1);
  localparam int OW = CW + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic          out_and, out_or, out_xor, out_overflow;
  logic [CW-1:0] out_count;
  logic [OW-1:0] obs;

  int checks = 0;
  int errors = 0;

  frame_reduce #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_and      (out_and),
    .out_or       (out_or),
    .out_xor      (out_xor),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, out_and, out_or, out_xor, out_count, out_overflow};

  function automatic logic [OW-1:0] res(input logic v, input logic a, input logic o,
                                        input logic x, input int n, input logic ovf);
    return {v, a, o, x, CW'(n), ovf};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    logic [OW-1:0] exp;
    in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    exp = res(1, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_word got=%h exp=%h", obs, exp); end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_gap_frame();
    logic [OW-1:0] exp;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0001; in_last = 1'b0;
    cycle();
    in_valid = 1'b0; in_data = 4'b1010; in_last = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_no_early_result got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b0;
    cycle();
    in_data = 4'b0011; in_last = 1'b1;
    cycle();
    in_valid = 1'b0;
    exp = res(1, 0, 1, 1, 3, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL gap_frame got=%h exp=%h", obs, exp); end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] exp;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0110; in_last = 1'b1;
    cycle();
    exp = res(1, 0, 1, 0, 1, 0);
    in_data = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, obs, exp); end
      cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    cycle();
    in_valid = 1'b0;
    exp = res(1, 0, 0, 0, 1, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_no_bubble got=%h exp=%h", obs, exp); end
    cycle();
  endtask

  task automatic test_overflow();
    logic [OW-1:0] exp;
    int lens[3] = '{16, 17, 18};
    foreach (lens[k]) begin
      out_ready = 1'b0;
      for (int i = 0; i < lens[k]; i++) begin
        in_valid = 1'b1; in_data = 4'b1111; in_last = (i == lens[k] - 1);
        cycle();
      end
      in_valid = 1'b0;
      exp = res(1, 1, 1, 0, MW, lens[k] > MW);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ovf_len%0d got=%h exp=%h", lens[k], obs, exp); end
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 4'b0101; in_last = 1'b0;
      cycle();
      in_data = 4'b0100; in_last = 1'b1;
      cycle();
      in_valid = 1'b0;
      exp = res(1, 0, 1, 1, 2, 0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ovf_after_len%0d got=%h exp=%h", lens[k], obs, exp); end
      cycle();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [OW-1:0] exp;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'b1111; in_last = 1'b0;
    cycle();
    cycle();
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    cycle();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midrst_outputs got=%h exp=0", obs); end
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 4'b1000; in_last = 1'b1;
    cycle();
    in_valid = 1'b0;
    exp = res(1, 0, 1, 1, 1, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL midrst_frame got=%h exp=%h", obs, exp); end
    cycle();
  endtask

  task automatic test_random();
    logic [W-1:0]  frame[$];
    logic          pend = 1'b0;
    logic [OW-1:0] pend_res = '0;
    logic          exp_rdy, acc;
    logic          a, o, x;
    int            n, results = 0;
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = W'($urandom);
      in_last   = ((c % 600) < 450) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      exp_rdy = !pend || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      checks++;
      if (out_valid !== pend) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, pend); end
      if (pend) begin
        checks++;
        if (obs !== pend_res) begin errors++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", c, obs, pend_res); end
      end
      acc = in_valid && exp_rdy;
      @(posedge clk);
      if (pend && out_ready) pend = 1'b0;
      if (acc) begin
        frame.push_back(in_data);
        if (in_last) begin
          a = 1'b1; o = 1'b0; x = 1'b0;
          foreach (frame[i]) for (int b = 0; b < W; b++) begin
            a = a & frame[i][b];
            o = o | frame[i][b];
            x = x ^ frame[i][b];
          end
          n = frame.size();
          pend_res = res(1, a, o, x, (n > MW) ? MW : n, n > MW);
          pend = 1'b1;
          results++;
          frame.delete();
        end
      end
      #1;
    end
    checks++;
    if (results < 50) begin errors++; $display("FAIL rand_result_count got=%0d exp>=50", results); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap_frame();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
